// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Brings a PLL out of reset and qualifies its lock. Only after lock has been
// stable for a while does it enable the PLL-clocked datapath. A lock that never
// arrives is retried a bounded number of times and then latched as a fault.
// A lock lost while running sends the sequencer back through a PLL reset.
//
// Status outputs are levels, not a handshake. ready is high for exactly as long
// as the state register holds RUN. scken is the registered enable that
// downstream logic qualifies its work with. Neither signal waits for an
// acknowledge.

module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       clken,
    output logic       pll_rst,
    output logic       scken,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [3:0] loss_cnt,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // Terminal counts of the shared cycle timer, one per timed state.
    localparam logic [9:0] RST_LAST     = 10'(RST_CYCLES - 1);
    localparam logic [9:0] STABLE_LAST  = 10'(LOCK_STABLE - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(LOCK_TIMEOUT - 1);
    localparam logic [1:0] RETRY_LIMIT  = 2'(MAX_RETRY);
    localparam logic [3:0] LOSS_MAX     = 4'hF;

    state_e     state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic [1:0] retry_q, retry_d;
    logic [1:0] retry_inc;
    logic [3:0] loss_q, loss_d;
    logic       scken_q, scken_d;
    logic       sync1_q, sync1_d;
    logic       lock_s_q, lock_s_d;

    // Two-flop lock synchronizer. It is flushed while the PLL is held in
    // reset. A PLL in reset says nothing meaningful about lock, so a stale
    // high must not be allowed to shortcut the qualification that follows.
    always_comb begin
        sync1_d  = pll_lock;
        lock_s_d = sync1_q;
        if (state_q == ST_PLL_RST) begin
            sync1_d  = 1'b0;
            lock_s_d = 1'b0;
        end
    end

    // Next state, shared timer, and the retry and loss counters.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 10'd1;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + 2'd1;

        case (state_q)
            ST_PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = 10'd0;
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    timer_d = 10'd0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    timer_d = 10'd0;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end
            end

            ST_STABLE: begin
                // Any low sample throws away the qualification so far. The
                // PLL is not reset again, because it did lock at least once.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = 10'd0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    timer_d = 10'd0;
                    retry_d = 2'd0;
                end
            end

            ST_RUN: begin
                timer_d = 10'd0;
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                    if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + 4'd1;
                    end
                end
            end

            ST_FAULT: begin
                // Terminal until rst. The timer is parked at zero.
                timer_d = 10'd0;
            end

            default: begin
                state_d = ST_PLL_RST;
                timer_d = 10'd0;
            end
        endcase
    end

    // The datapath enable is registered from the current state. Leaving RUN
    // therefore drops it on the same edge, and clken reaches it one cycle late.
    always_comb begin
        scken_d = (state_q == ST_RUN) && lock_s_q && clken;
    end

    // All state registers, with a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PLL_RST;
            timer_q  <= 10'd0;
            retry_q  <= 2'd0;
            loss_q   <= 4'd0;
            scken_q  <= 1'b0;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            scken_q  <= scken_d;
            sync1_q  <= sync1_d;
            lock_s_q <= lock_s_d;
        end
    end

    // These status outputs decode the state register only. No input reaches
    // them combinationally.
    assign pll_rst   = (state_q == ST_PLL_RST) || (state_q == ST_FAULT);
    assign ready     = (state_q == ST_RUN);
    assign fault     = (state_q == ST_FAULT);
    assign scken     = scken_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with short timing parameters.
// The driver applies one input vector per cycle. For each vector it queues the
// outputs expected after the next edge, using timelines worked out by hand.
// The monitor checks the queue against the DUT on every falling edge.

module tb_pll_lock_sequencer;

    localparam int W = 10;  // {pll_rst, ready, fault, scken, retry_cnt[1:0], loss_cnt[3:0]}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       clken = 1'b0;
    logic       pll_rst;
    logic       scken;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [3:0] loss_cnt;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_tag;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(20),
        .MAX_RETRY   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .clken    (clken),
        .pll_rst  (pll_rst),
        .scken    (scken),
        .ready    (ready),
        .fault    (fault),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt),
        .dbg_state(dbg_state)
    );

    function automatic logic [W-1:0] pack(input logic pr, input logic rd, input logic ft,
                                          input logic sk, input int rc, input int lc);
        logic [1:0] rc_v;
        logic [3:0] lc_v;
        rc_v = 2'(rc);
        lc_v = 4'(lc);
        return {pr, rd, ft, sk, rc_v, lc_v};
    endfunction

    // ---------------- driver ----------------
    // Apply inputs for the current cycle. Then queue the outputs expected
    // right after the coming edge.
    task automatic tick(input logic r, input logic l, input logic ce,
                        input logic [W-1:0] e, input string tag);
        rst      = r;
        pll_lock = l;
        clken    = ce;
        @(posedge clk);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
    endtask

    // One reset cycle. Afterwards the PLL is in reset and every count is zero.
    task automatic do_reset(input string tag);
        tick(1'b1, 1'b1, 1'b1, pack(1'b1, 1'b0, 1'b0, 1'b0, 0, 0), tag);
    endtask

    // Lock held high with clken high. Relative to the reset cycle (cycle 0),
    // pll_rst is high in cycles 0-3, ready is high from 15, and scken is high
    // from 16.
    task automatic lock_seq(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            int k;
            k = c + 1;
            tick(1'b0, 1'b1, 1'b1,
                 pack(k <= 3, k >= 15, 1'b0, k >= 16, 0, 0), tag);
        end
    endtask

    // Lock never arrives. Cycles 4-23 and 28-47 are timeouts, with a PLL
    // reset pulse in cycles 24-27. The fault is latched from cycle 48.
    task automatic no_lock(input int n);
        for (int c = 0; c < n; c++) begin
            int k;
            int rc;
            k  = c + 1;
            rc = (k >= 48) ? 2 : ((k >= 24) ? 1 : 0);
            tick(1'b0, 1'b0, 1'b1,
                 pack((k <= 3) || (k >= 24 && k <= 27) || (k >= 48),
                      1'b0, k >= 48, 1'b0, rc, 0), "no_lock");
        end
    endtask

    // Lock is dropped during cycle 10. The synchronized low lands at stable
    // count 5 in cycle 12. Lock is back in cycle 13 (WAIT_LOCK), then STABLE
    // runs 14-21, RUN starts at 22, and scken follows at 23.
    task automatic stable_glitch(input int n);
        for (int c = 0; c < n; c++) begin
            int k;
            k = c + 1;
            tick(1'b0, (c != 10), 1'b1,
                 pack(k <= 3, k >= 22, 1'b0, k >= 23, 0, 0), "stable_glitch");
        end
    endtask

    // Starting in RUN, lock is dropped for cycle 0 only. ready and scken are
    // still high in cycles 1-2, pll_rst pulses in cycles 3-6, and loss
    // increments in cycle 3. RUN comes back at 18 and scken at 19.
    task automatic loss_event(input int prior);
        int nl;
        nl = (prior >= 15) ? 15 : prior + 1;
        for (int r = 0; r < 20; r++) begin
            int k;
            k = r + 1;
            tick(1'b0, (r != 0), 1'b1,
                 pack(k >= 3 && k <= 6, (k <= 2) || (k >= 18), 1'b0,
                      (k <= 2) || (k >= 19), 0, (k >= 3) ? nl : prior),
                 "loss_event");
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {pll_rst, ready, fault, scken, retry_cnt, loss_cnt};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s @%0t: got pr/rd/ft/sk/rc/lc=%b required %b",
                         mon_tag, $time, mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset("reset");
        do_reset("reset");
        lock_seq(24, "lock_seq");

        // rst while in RUN, then a PLL that never locks.
        do_reset("rst_in_run");
        no_lock(60);

        // rst while in FAULT. The full sequence must repeat.
        do_reset("rst_in_fault");
        lock_seq(24, "after_fault_rst");

        // A one-cycle lock drop during STABLE.
        do_reset("reset");
        stable_glitch(30);

        // Sixteen lock losses in RUN. The loss count saturates at 15.
        for (int i = 0; i < 16; i++) begin
            loss_event(i);
        end

        // Toggle clken in RUN. scken follows it one cycle later.
        for (int i = 0; i < 16; i++) begin
            logic ce;
            ce = 1'($urandom_range(0, 1));
            tick(1'b0, 1'b1, ce, pack(1'b0, 1'b1, 1'b0, ce, 0, 15), "clken_follow");
        end

        // rst while in RUN clears the loss count and restarts the sequence.
        do_reset("rst_in_run2");
        lock_seq(24, "rst_in_run_seq");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8: cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE, default 16: consecutive synchronized lock cycles required before run.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1000: cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter MAX_RETRY, default 3: lock timeouts tolerated before fault (1..3).
REQ-005 SHALL have port clk, input, 1 bit: reference clock (PLL input clock), the only clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1 bit: raw PLL lock, asynchronous to clk.
REQ-008 SHALL have port clken, input, 1 bit: downstream count/clock-enable request.
REQ-009 SHALL have port pll_rst, output, 1 bit: reset to the PLL.
REQ-010 SHALL have port scken, output, 1 bit: qualified clock enable for the PLL-clocked datapath.
REQ-011 SHALL have port ready, output, 1 bit: high exactly while state is RUN.
REQ-012 SHALL have port fault, output, 1 bit: sticky lock failure.
REQ-013 SHALL have port retry_cnt, output, 2 bits: lock timeouts since the last RUN entry or rst.
REQ-014 SHALL have port loss_cnt, output, 4 bits: lock losses seen in RUN, saturating.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer; lock_s (second flop) SHALL be the only lock value used.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT with one shared 10-bit cycle timer.
REQ-017 PLL_RST: pll_rst=1; timer counts 0..RST_CYCLES-1, then go to WAIT_LOCK with timer cleared.
REQ-018 WAIT_LOCK: lock_s=1 -> STABLE (timer cleared); else timer==LOCK_TIMEOUT-1 -> increment retry_cnt, then FAULT if the incremented value equals MAX_RETRY, else PLL_RST.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK (timer cleared, retry_cnt unchanged); timer==LOCK_STABLE-1 with lock_s=1 -> RUN.
REQ-020 RUN: ready=1; retry_cnt cleared on entry; lock_s=0 -> PLL_RST and loss_cnt increments, saturating at 15.
REQ-021 FAULT: pll_rst=1, fault=1, scken=0, ready=0; held until rst.
REQ-022 scken SHALL be registered: scken <= (state==RUN) & lock_s & clken, so it drops on the same edge RUN is left.
REQ-023 scken SHALL rise one cycle after the RUN entry edge when clken is high; clken toggling in RUN SHALL affect scken with 1-cycle latency only.
REQ-024 pll_rst, ready and fault SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-025 A pll_lock glitch shorter than 1 cycle SHALL be tolerated without an X on any output; any lock_s=0 sample in STABLE restarts the qualification.

Reset
REQ-026 rst=1 at a clk edge SHALL load state=PLL_RST, timer=0, retry_cnt=0, loss_cnt=0, scken=0, both synchronizer flops=0.
REQ-027 While rst=1: pll_rst=1, ready=0, fault=0, scken=0; rst mid-RUN or in FAULT SHALL abort to PLL_RST and clear all counters.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=20, MAX_RETRY=2)
REQ-028 pll_lock=1 constant, clken=1, rst released at cycle 0 -> pll_rst high cycles 0-3; ready first high at cycle 15 (4 PLL_RST + 2 sync + 1 WAIT_LOCK + 8 STABLE); scken high from cycle 16.
REQ-029 pll_lock=0 forever -> two 20-cycle WAIT_LOCK timeouts separated by a 4-cycle pll_rst pulse; retry_cnt 1 then 2; fault=1 and pll_rst=1 held until rst.
REQ-030 In STABLE, pll_lock low for 1 cycle at stable count 5 -> return to WAIT_LOCK; RUN reached a full 8 qualified cycles after lock_s returns high.
REQ-031 In RUN with clken=1, drop pll_lock -> scken and ready fall on the same edge (2 cycles after the drop), loss_cnt 0->1, pll_rst pulses 4 cycles; 16 such losses -> loss_cnt stays 15.
REQ-032 Assert rst for 1 cycle during FAULT, then during RUN -> fault=0, counters=0, state PLL_RST the next cycle; the full lock sequence repeats as in REQ-028.
